// File: rtl/pipelined_adder.sv
// Chunked, pipelined adder/subtractor: one CW-bit chunk per stage, carry rippled through stage registers.
// Define PIPE_ADDER_OVF_EN to produce a registered signed-overflow flag; otherwise ovf_out is tied low.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             sub_in,
  input  logic             cin_in,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [WIDTH-1:0] c_out,
  output logic             cout_out,
  output logic             ovf_out,
  output logic             valid_out,
  input  logic             ready_out
);
  localparam int CW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  logic adv;
  assign adv      = !valid_out || ready_out;
  assign ready_in = adv;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    // Operands not yet consumed shrink by one chunk per stage; the low chunk is this stage's.
    localparam int IW = (STAGES - k) * CW;
    localparam int RW = (k + 1) * CW;

    logic [IW-1:0] a_s, b_s;
    logic          c_s, v_s;
    logic [CW:0]   sum;
    logic [RW-1:0] res_d, res_q;
    logic          cy_d, cy_q, vld_d, vld_q;

    if (k == 0) begin : g_src
      assign a_s = a_in;
      assign b_s = sub_in ? ~b_in : b_in;
      assign c_s = sub_in | cin_in;
      assign v_s = valid_in;
      always_comb res_d = adv ? sum[CW-1:0] : res_q;
    end else begin : g_src
      assign a_s = stg[k-1].g_ops.a_q;
      assign b_s = stg[k-1].g_ops.b_q;
      assign c_s = stg[k-1].cy_q;
      assign v_s = stg[k-1].vld_q;
      always_comb res_d = adv ? {sum[CW-1:0], stg[k-1].res_q} : res_q;
    end

    assign sum = {1'b0, a_s[CW-1:0]} + {1'b0, b_s[CW-1:0]} + {{CW{1'b0}}, c_s};

    always_comb begin
      vld_d = adv ? v_s : vld_q;
      cy_d  = adv ? sum[CW] : cy_q;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        res_q <= '0;
      end else begin
        vld_q <= vld_d;
        cy_q  <= cy_d;
        res_q <= res_d;
      end
    end

    if (k < L) begin : g_ops
      logic [IW-CW-1:0] a_d, a_q, b_d, b_q;
      always_comb begin
        a_d = adv ? a_s[IW-1:CW] : a_q;
        b_d = adv ? b_s[IW-1:CW] : b_q;
      end
      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign c_out     = stg[L].res_q;
  assign cout_out  = stg[L].cy_q;
  assign valid_out = stg[L].vld_q;

`ifdef PIPE_ADDER_OVF_EN
  // Operand sign bits ride along in the top chunk, so the last stage sees them directly.
  logic ovf_d, ovf_q;
  always_comb begin
    ovf_d = ovf_q;
    if (adv)
      ovf_d = (stg[L].a_s[CW-1] == stg[L].b_s[CW-1]) && (stg[L].sum[CW-1] != stg[L].a_s[CW-1]);
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign ovf_out = ovf_q;
`else
  assign ovf_out = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=32, STAGES=4): vector table, latency, stall and reset sequences.
module tb_pipelined_adder;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_in, b_in, c_out;
  logic        sub_in, cin_in, valid_in, ready_in, cout_out, ovf_out, valid_out, ready_out;

  always #5 clk = ~clk;

  pipelined_adder dut (
    .clk_in(clk), .rst_in(rst), .a_in(a_in), .b_in(b_in), .sub_in(sub_in), .cin_in(cin_in),
    .valid_in(valid_in), .ready_in(ready_in), .c_out(c_out), .cout_out(cout_out),
    .ovf_out(ovf_out), .valid_out(valid_out), .ready_out(ready_out)
  );

  typedef struct { logic [31:0] c; logic cout; logic ovf; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic sub; logic cin; exp_t e; } vec_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   out_cnt = 0;
  int   base;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic exp_t mask(input exp_t e);
    exp_t r = e;
`ifndef PIPE_ADDER_OVF_EN
    r.ovf = 1'b0;
`endif
    return r;
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s, input logic c);
    exp_t        e;
    logic [31:0] bb;
    logic [32:0] t;
    bb     = s ? ~b : b;
    t      = {1'b0, a} + {1'b0, bb} + 33'(s ? 1'b1 : c);
    e.c    = t[31:0];
    e.cout = t[32];
    e.ovf  = (a[31] == bb[31]) && (t[31] != a[31]);
    return e;
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic s, input logic c,
                              input logic [31:0] ec, input logic ecout, input logic eovf);
    vec_t v;
    v.a = a; v.b = b; v.sub = s; v.cin = c;
    v.e.c = ec; v.e.cout = ecout; v.e.ovf = eovf;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst && valid_out && ready_out) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%h expected=none", c_out);
      end else begin
        mon_e = q.pop_front();
        out_cnt++;
        chk("res_c", c_out, mon_e.c);
        chk("res_cout", 32'(cout_out), 32'(mon_e.cout));
        chk("res_ovf", 32'(ovf_out), 32'(mon_e.ovf));
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input logic c, input exp_t e);
    bit ok;
    ok = 1'b0;
    a_in = a; b_in = b; sub_in = s; cin_in = c; valid_in = 1'b1;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (ready_in) begin
        q.push_back(mask(e));
        ok = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=ready_in_low expected=accept");
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (q.size() == 0) done = 1'b1;
    end
    chk("drain", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  vec_t vec[10];

  initial begin
    vec[0] = mk(32'h03C00000, 32'h00000004, 1'b0, 1'b0, 32'h03C00004, 1'b0, 1'b0);
    vec[1] = mk(32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0);
    vec[2] = mk(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
    vec[3] = mk(32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
    vec[4] = mk(32'h00000007, 32'h00000005, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0);
    vec[5] = mk(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
    vec[6] = mk(32'h0000FFFF, 32'h00000000, 1'b0, 1'b1, 32'h00010000, 1'b0, 1'b0);
    vec[7] = mk(32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1);
    vec[8] = mk(32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0);
    vec[9] = mk(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);

    rst = 1'b1; a_in = '0; b_in = '0; sub_in = 1'b0; cin_in = 1'b0; valid_in = 1'b0; ready_out = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_c", c_out, 32'd0);
    chk("rst_cout", 32'(cout_out), 32'd0);
    chk("rst_ovf", 32'(ovf_out), 32'd0);
    chk("rst_ready_in", 32'(ready_in), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; ready_out = 1'b1;
    @(posedge clk); #1;

    // Single op: valid_out must rise exactly on the 4th edge counting the accept edge.
    a_in = vec[0].a; b_in = vec[0].b; sub_in = vec[0].sub; cin_in = vec[0].cin; valid_in = 1'b1;
    @(negedge clk);
    chk("accept_ready", 32'(ready_in), 32'd1);
    q.push_back(mask(vec[0].e));
    @(posedge clk); #1;
    valid_in = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      chk("latency_valid", 32'(valid_out), 32'(e == 4));
      if (e < 4) @(posedge clk);
    end
    @(posedge clk); #1;

    for (int i = 1; i < 10; i++) send(vec[i].a, vec[i].b, vec[i].sub, vec[i].cin, vec[i].e);
    valid_in = 1'b0;
    drain();

    // Back-to-back stream with a 3-cycle consumer stall in the middle.
    base = out_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) send(32'(i), 32'(i), 1'b0, 1'b0, model(32'(i), 32'(i), 1'b0, 1'b0));
        valid_in = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 ready_out = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_ready_in", 32'(ready_in), 32'd0);
          @(posedge clk);
        end
        #1 ready_out = 1'b1;
      end
    join
    drain();
    chk("stream_count", 32'(out_cnt - base), 32'd8);

    // Reset with three operations in flight.
    send(32'h11111111, 32'h22222222, 1'b0, 1'b0, model(32'h11111111, 32'h22222222, 1'b0, 1'b0));
    send(32'h00000010, 32'h00000001, 1'b1, 1'b0, model(32'h00000010, 32'h00000001, 1'b1, 1'b0));
    send(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1, model(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b1));
    valid_in = 1'b0; ready_out = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", 32'(valid_out), 32'd1);
    chk("pre_rst_c", c_out, 32'h33333333);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(valid_out), 32'd0);
    chk("midrst_c", c_out, 32'd0);
    chk("midrst_cout", 32'(cout_out), 32'd0);
    chk("midrst_ovf", 32'(ovf_out), 32'd0);
    chk("midrst_ready_in", 32'(ready_in), 32'd1);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; ready_out = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_no_valid", 32'(valid_out), 32'd0);
    end
    @(posedge clk); #1;
    send(32'h12345678, 32'h00000008, 1'b1, 1'b0, model(32'h12345678, 32'h00000008, 1'b1, 1'b0));
    valid_in = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined integer adder/subtractor for the pipeline processor datapath, successor to the single-cycle combinational `adder`. Operands are split into `STAGES` equal chunks; one chunk is resolved per clock with carry rippled stage-to-stage, giving a shorter critical path at the cost of `STAGES` cycles of latency. A valid/ready handshake with full-pipeline stall lets it sit between producer and consumer stages that may back-pressure.

## Interface
- `WIDTH`, 32, operand/result width in bits.
- `STAGES`, 4, pipeline depth and chunk count; `WIDTH % STAGES == 0`, `1 <= STAGES <= WIDTH`; chunk width `CW = WIDTH/STAGES`.

- `clk_in` input 1: single clock, rising-edge.
- `rst_in` input 1: reset, asynchronous, active-high.
- `a_in` input WIDTH: operand A.
- `b_in` input WIDTH: operand B.
- `sub_in` input 1: 0 = A+B+cin, 1 = A+~B+1 (cin ignored).
- `cin_in` input 1: carry-in for add mode.
- `valid_in` input 1: operands valid this cycle.
- `ready_in` output 1: block can accept operands.
- `c_out` output WIDTH: result.
- `cout_out` output 1: carry out of bit WIDTH-1 (sub mode: 1 = no borrow).
- `ovf_out` output 1: signed overflow flag (see Configuration).
- `valid_out` output 1: result valid.
- `ready_out` input 1: consumer accepts result.

## Operation
- Stage k (0..STAGES-1) holds: valid bit, result chunks 0..k, carry into chunk k+1, delayed A and inverted-or-not B chunks k+1..STAGES-1, and (with macro) operand sign bits.
- Stage 0 computes chunk 0 = A[CW-1:0] + B'[CW-1:0] + c0, where B' = sub ? ~B : B, c0 = sub ? 1 : cin.
- Stage k computes chunk k from its delayed operand chunks and the registered carry from stage k-1.
- Final stage drives `c_out`, `cout_out`, `ovf_out`, `valid_out` directly from registers.
- Global advance `adv = !valid_out || ready_out`; `ready_in = adv` (combinational).
- On `adv`: all stages shift forward; stage 0 loads `valid_in` (bubble if 0). On `!adv`: every stage holds, including bubbles.
- Transfer in when `valid_in && ready_in`; transfer out when `valid_out && ready_out`.
- Arithmetic is modulo 2^WIDTH; operands treated as unsigned for `cout_out`, two's complement for `ovf_out`.
- `STAGES = 1` degenerates to a registered single-cycle adder.

## Timing
- Reset (async assert, sync release): all stage valid bits 0; data/carry registers 0; outputs `c_out=0`, `cout_out=0`, `ovf_out=0`, `valid_out=0`; `ready_in=1`.
- Latency: operand accepted on edge N appears on `valid_out`/`c_out` after edge N+STAGES-1 (i.e. STAGES edges including the accept edge), absent stalls.
- Throughput: one operation per cycle while `ready_out=1`.
- Stall: while `valid_out=1 && ready_out=0`, outputs stable and `ready_in=0`; pipeline resumes the cycle `ready_out` returns high.
- Simultaneous output transfer and input transfer in same cycle is legal and loses nothing.
- Reset mid-operation: all in-flight operations discarded, no `valid_out` pulse until new operands traverse the full latency.
- `valid_in` ignored while `ready_in=0`; producer must hold operands.

## Configuration
- `PIPE_ADDER_OVF_EN` defined: sign bits of A and B' carried through pipeline; `ovf_out = (a_sign == b'_sign) && (c_out[WIDTH-1] != a_sign)`, registered with result.
- Not defined: sign-bit registers omitted; `ovf_out` tied to 0.

## Test plan
- Reset, then A=0x03C00000, B=0x00000004, add, cin=0 -> after 4 edges `valid_out=1`, `c_out=0x03C00004`, `cout_out=0`.
- Chunk-boundary carry: A=0x00FFFFFF, B=0x00000001 -> `c_out=0x01000000`; A=0xFFFFFFFF, B=1 -> `c_out=0`, `cout_out=1`.
- Subtract: A=5, B=7, sub=1 -> `c_out=0xFFFFFFFE`, `cout_out=0`; A=7, B=5 -> `c_out=2`, `cout_out=1`.
- Overflow (macro defined): A=0x7FFFFFFF, B=1 -> `c_out=0x80000000`, `ovf_out=1`; macro undefined -> `ovf_out=0`.
- Back-pressure: stream 8 back-to-back adds (i+i), hold `ready_out=0` 3 cycles mid-stream -> `ready_in` low during stall, all 8 results in order, none duplicated/lost.
- Assert `rst_in` with 3 ops in flight -> outputs return to reset values immediately, no stale `valid_out` after release.
